hpdcache_refill_unit: RTL and testbench
=======================================

HPDCACHE_REFILL_UNIT -- requirements
Module: hpdcache_refill_unit

Interface
REQ-001 SHALL have parameter MSHR_SET_W, default 5, MSHR set index width.
REQ-002 SHALL have parameter MSHR_WAY_W, default 2, MSHR way index width.
REQ-003 SHALL have parameter NLINE_W, default 34, cache line number width.
REQ-004 SHALL have parameters TID_W, default 6, and SID_W, default 3, request and source ID widths.
REQ-005 SHALL have parameters WORD_W, default 64, LINE_WORDS, default 8, and BEAT_WORDS, default 2; BEATS = LINE_WORDS/BEAT_WORDS; WIDX_W = clog2(LINE_WORDS).
REQ-006 SHALL have ports clk_i in 1 clock and rst_ni in 1 reset; reset rst_ni is asynchronous, active-low; clock is clk_i.
REQ-007 SHALL have memory response ports mem_rsp_valid_i in 1, mem_rsp_ready_o out 1, mem_rsp_id_i in MSHR_WAY_W+MSHR_SET_W ({way,set}), mem_rsp_data_i in BEAT_WORDS*WORD_W, mem_rsp_error_i in 1 and mem_rsp_last_i in 1.
REQ-008 SHALL have MSHR grant and ack request ports mshr_ack_gnt_i in 1 (arbiter grant, no concurrent alloc/check), mshr_ack_o out 1, mshr_ack_cs_o out 1, mshr_ack_set_o out MSHR_SET_W and mshr_ack_way_o out MSHR_WAY_W.
REQ-009 SHALL have MSHR ack result ports mshr_ack_req_id_i in TID_W, mshr_ack_src_id_i in SID_W, mshr_ack_nline_i in NLINE_W, mshr_ack_word_i in WIDX_W, mshr_ack_need_rsp_i in 1 and mshr_ack_is_prefetch_i in 1, all valid one cycle after ack.
REQ-010 SHALL have cache data write ports refill_req_o out 1, refill_gnt_i in 1, refill_nline_o out NLINE_W, refill_beat_o out clog2(BEATS), refill_data_o out BEAT_WORDS*WORD_W, refill_last_o out 1 and refill_error_o out 1.
REQ-011 SHALL have core response ports core_rsp_valid_o out 1, core_rsp_ready_i in 1, core_rsp_tid_o out TID_W, core_rsp_sid_o out SID_W, core_rsp_data_o out WORD_W and core_rsp_error_o out 1.
REQ-012 SHALL have port busy_o out 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, META, DATA and RSP.
REQ-014 IDLE: mshr_ack_o = mshr_ack_cs_o = mem_rsp_valid_i & mshr_ack_gnt_i; set/way driven from mem_rsp_id_i; mem_rsp_ready_o=0; on ack go META and register id.
REQ-015 IDLE with mem_rsp_valid_i & ~mshr_ack_gnt_i: no ack, no beat consumed, stay IDLE.
REQ-016 META (exactly 1 cycle): capture all mshr_ack_*_i fields into registers, clear beat counter and sticky error, go DATA.
REQ-017 DATA: refill_req_o=mem_rsp_valid_i; mem_rsp_ready_o=refill_gnt_i; refill_data_o=mem_rsp_data_i (combinational pass-through); refill_nline_o=captured nline; refill_beat_o=beat counter.
REQ-018 Beat handshake = mem_rsp_valid_i & refill_gnt_i; only a handshake increments the beat counter; a valid without grant holds all state.
REQ-019 On a handshake where counter == word_q/BEAT_WORDS, SHALL capture word (word_q mod BEAT_WORDS) of the beat into the response data register.
REQ-020 Error flag: sticky OR of mem_rsp_error_i over handshaken beats; refill_error_o = flag | mem_rsp_error_i; refill_last_o=1 on beat BEATS-1 (cache uses it to update directory valid only if ~refill_error_o).
REQ-021 Handshake on beat BEATS-1: go RSP if need_rsp_q, else IDLE; counter wraps to 0.
REQ-022 mem_rsp_last_i SHALL be 1 exactly on beat BEATS-1; a mismatch is a protocol error (simulation assertion), behaviour still driven by counter.
REQ-023 RSP: core_rsp_valid_o=1 holding tid/sid/data/error stable until core_rsp_ready_i; handshake -> IDLE; no memory beats accepted in RSP.
REQ-024 Prefetch lines (is_prefetch_q=1) SHALL still be written; response only if need_rsp_q.
REQ-025 Latency: ack to first refill write opportunity = 2 cycles; last beat handshake to core_rsp_valid_o = 1 cycle.

Reset
REQ-026 On reset: state IDLE; all outputs 0 (mem_rsp_ready_o, mshr_ack_o, refill_req_o, core_rsp_valid_o, busy_o); counter, error flag, captured registers 0.
REQ-027 Reset mid-operation SHALL abort without further ack or write; the MSHR entry is already released by the earlier ack.

Verification
REQ-028 id={way 2,set 7}, gnt=1, word=5, need_rsp=1, 4 beats granted back-to-back -> ack set=7 way=2 cycle 0; writes beats 0..3 cycles 2..5; core_rsp data = beat 2 upper word, cycle 6.
REQ-029 mshr_ack_gnt_i low 3 cycles with valid -> no ack, ready=0, busy_o=0 until grant.
REQ-030 refill_gnt_i toggles 1,0,1,0... -> exactly 4 writes, beat indices 0,1,2,3, data unchanged across stall cycles.
REQ-031 error on beat 1 only -> refill_error_o=1 on beats 1..3, core_rsp_error_o=1.
REQ-032 need_rsp=0, prefetch=1 -> 4 writes, no core_rsp_valid_o, IDLE after last beat.
REQ-033 core_rsp_ready_i low 5 cycles -> rsp fields stable, mem_rsp_ready_o=0; reset asserted in DATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/hpdcache_refill_unit.sv
// hpdcache_refill_unit
//   Drains one memory refill response into the cache data array and, when the
//   originating miss asked for it, returns the requested word to the core.
//   Flow: IDLE (ack the MSHR for the incoming response id) -> META (MSHR lookup
//   result arrives) -> DATA (stream BEATS beats into the cache) -> RSP (optional
//   core response) -> IDLE.
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   mem_rsp_*            memory refill response stream (id = {way,set})
//   mshr_ack_*           MSHR arbiter grant, ack request and one-cycle-late ack result
//   refill_*             cache data array write request, one beat per grant
//   core_rsp_*           core load response for the missing word
//   busy_o               high whenever the unit is not idle
module hpdcache_refill_unit #(
   parameter int unsigned MSHR_SET_W = 5,
   parameter int unsigned MSHR_WAY_W = 2,
   parameter int unsigned NLINE_W    = 34,
   parameter int unsigned TID_W      = 6,
   parameter int unsigned SID_W      = 3,
   parameter int unsigned WORD_W     = 64,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned BEAT_WORDS = 2,
   localparam int unsigned BEATS     = LINE_WORDS / BEAT_WORDS,
   localparam int unsigned WIDX_W    = $clog2(LINE_WORDS),
   localparam int unsigned BEAT_W    = $clog2(BEATS),
   localparam int unsigned ID_W      = MSHR_WAY_W + MSHR_SET_W,
   localparam int unsigned BDATA_W   = BEAT_WORDS * WORD_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mem_rsp_valid_i,
   output logic                  mem_rsp_ready_o,
   input  logic [ID_W-1:0]       mem_rsp_id_i,
   input  logic [BDATA_W-1:0]    mem_rsp_data_i,
   input  logic                  mem_rsp_error_i,
   input  logic                  mem_rsp_last_i,
   input  logic                  mshr_ack_gnt_i,
   output logic                  mshr_ack_o,
   output logic                  mshr_ack_cs_o,
   output logic [MSHR_SET_W-1:0] mshr_ack_set_o,
   output logic [MSHR_WAY_W-1:0] mshr_ack_way_o,
   input  logic [TID_W-1:0]      mshr_ack_req_id_i,
   input  logic [SID_W-1:0]      mshr_ack_src_id_i,
   input  logic [NLINE_W-1:0]    mshr_ack_nline_i,
   input  logic [WIDX_W-1:0]     mshr_ack_word_i,
   input  logic                  mshr_ack_need_rsp_i,
   input  logic                  mshr_ack_is_prefetch_i,
   output logic                  refill_req_o,
   input  logic                  refill_gnt_i,
   output logic [NLINE_W-1:0]    refill_nline_o,
   output logic [BEAT_W-1:0]     refill_beat_o,
   output logic [BDATA_W-1:0]    refill_data_o,
   output logic                  refill_last_o,
   output logic                  refill_error_o,
   output logic                  core_rsp_valid_o,
   input  logic                  core_rsp_ready_i,
   output logic [TID_W-1:0]      core_rsp_tid_o,
   output logic [SID_W-1:0]      core_rsp_sid_o,
   output logic [WORD_W-1:0]     core_rsp_data_o,
   output logic                  core_rsp_error_o,
   output logic                  busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] META = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] RSP  = 2'd3;

   logic [1:0]            state_q;
   logic [MSHR_SET_W-1:0] set_q;
   logic [MSHR_WAY_W-1:0] way_q;
   logic [TID_W-1:0]      tid_q;
   logic [SID_W-1:0]      sid_q;
   logic [NLINE_W-1:0]    nline_q;
   logic [WIDX_W-1:0]     word_q;
   logic                  need_rsp_q;
   logic                  is_prefetch_q;
   logic [BEAT_W-1:0]     cnt_q;
   logic                  err_q;
   logic [WORD_W-1:0]     rsp_data_q;

   logic        in_idle, in_data;
   logic        ack;
   logic        beat_hs;
   logic        last_beat;
   logic [31:0] word_beat;
   logic [31:0] word_off;
   logic        word_hit;

   assign in_idle = (state_q == IDLE);
   assign in_data = (state_q == DATA);

   // rst_ni in the ack term keeps a reset from leaking an ack while the
   // memory side still shows a valid response.
   assign ack = in_idle & mem_rsp_valid_i & mshr_ack_gnt_i;

   assign mshr_ack_o     = rst_ni & ack;
   assign mshr_ack_cs_o  = rst_ni & ack;
   assign mshr_ack_set_o = in_idle ? mem_rsp_id_i[MSHR_SET_W-1:0] : set_q;
   assign mshr_ack_way_o = in_idle ? mem_rsp_id_i[MSHR_SET_W +: MSHR_WAY_W] : way_q;

   assign beat_hs   = in_data & mem_rsp_valid_i & refill_gnt_i;
   assign last_beat = (cnt_q == BEAT_W'(BEATS - 1));

   // Beat holding the requested word, and the word's slot within that beat.
   assign word_beat = 32'(word_q) / BEAT_WORDS;
   assign word_off  = 32'(word_q) % BEAT_WORDS;
   assign word_hit  = (32'(cnt_q) == word_beat);

   assign mem_rsp_ready_o = in_data & refill_gnt_i;
   assign refill_req_o    = in_data & mem_rsp_valid_i;
   assign refill_nline_o  = nline_q;
   assign refill_beat_o   = cnt_q;
   assign refill_data_o   = in_data ? mem_rsp_data_i : '0;
   assign refill_last_o   = in_data & last_beat;
   // Include the current beat's error so a failing last beat already blocks
   // the directory valid update.
   assign refill_error_o  = in_data & (err_q | mem_rsp_error_i);

   assign core_rsp_valid_o = (state_q == RSP);
   assign core_rsp_tid_o   = tid_q;
   assign core_rsp_sid_o   = sid_q;
   assign core_rsp_data_o  = rsp_data_q;
   assign core_rsp_error_o = err_q;

   assign busy_o = ~in_idle;

   // Prefetch lines take exactly the same path; the flag is kept for debug.
   logic unused_prefetch;
   assign unused_prefetch = is_prefetch_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         set_q         <= '0;
         way_q         <= '0;
         tid_q         <= '0;
         sid_q         <= '0;
         nline_q       <= '0;
         word_q        <= '0;
         need_rsp_q    <= 1'b0;
         is_prefetch_q <= 1'b0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         rsp_data_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ack) begin
                  set_q   <= mem_rsp_id_i[MSHR_SET_W-1:0];
                  way_q   <= mem_rsp_id_i[MSHR_SET_W +: MSHR_WAY_W];
                  state_q <= META;
               end
            end
            META: begin
               tid_q         <= mshr_ack_req_id_i;
               sid_q         <= mshr_ack_src_id_i;
               nline_q       <= mshr_ack_nline_i;
               word_q        <= mshr_ack_word_i;
               need_rsp_q    <= mshr_ack_need_rsp_i;
               is_prefetch_q <= mshr_ack_is_prefetch_i;
               cnt_q         <= '0;
               err_q         <= 1'b0;
               state_q       <= DATA;
            end
            DATA: begin
               if (beat_hs) begin
                  err_q <= err_q | mem_rsp_error_i;
                  if (word_hit) rsp_data_q <= mem_rsp_data_i[word_off*WORD_W +: WORD_W];
                  if (last_beat) begin
                     cnt_q   <= '0;
                     state_q <= need_rsp_q ? RSP : IDLE;
                  end else begin
                     cnt_q <= cnt_q + BEAT_W'(1);
                  end
               end
            end
            default: begin
               if (core_rsp_ready_i) state_q <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // The memory's last flag must agree with the beat counter; the counter
   // still governs behaviour when it does not.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      beat_hs |-> (mem_rsp_last_i == last_beat));
`endif

endmodule

// File: tb/tb_hpdcache_refill_unit.sv
// Cycle-accurate directed bench for hpdcache_refill_unit: each table row is
// one clock cycle of inputs plus the outputs expected in that cycle.
module tb_hpdcache_refill_unit;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          mem_rsp_valid_i, mem_rsp_ready_o;
   logic [6:0]    mem_rsp_id_i;
   logic [127:0]  mem_rsp_data_i;
   logic          mem_rsp_error_i, mem_rsp_last_i;
   logic          mshr_ack_gnt_i, mshr_ack_o, mshr_ack_cs_o;
   logic [4:0]    mshr_ack_set_o;
   logic [1:0]    mshr_ack_way_o;
   logic [5:0]    mshr_ack_req_id_i;
   logic [2:0]    mshr_ack_src_id_i;
   logic [33:0]   mshr_ack_nline_i;
   logic [2:0]    mshr_ack_word_i;
   logic          mshr_ack_need_rsp_i, mshr_ack_is_prefetch_i;
   logic          refill_req_o, refill_gnt_i;
   logic [33:0]   refill_nline_o;
   logic [1:0]    refill_beat_o;
   logic [127:0]  refill_data_o;
   logic          refill_last_o, refill_error_o;
   logic          core_rsp_valid_o, core_rsp_ready_i;
   logic [5:0]    core_rsp_tid_o;
   logic [2:0]    core_rsp_sid_o;
   logic [63:0]   core_rsp_data_o;
   logic          core_rsp_error_o, busy_o;

   always #5 clk_i = ~clk_i;

   hpdcache_refill_unit dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
      .mem_rsp_error_i(mem_rsp_error_i), .mem_rsp_last_i(mem_rsp_last_i),
      .mshr_ack_gnt_i(mshr_ack_gnt_i), .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
      .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
      .mshr_ack_req_id_i(mshr_ack_req_id_i), .mshr_ack_src_id_i(mshr_ack_src_id_i),
      .mshr_ack_nline_i(mshr_ack_nline_i), .mshr_ack_word_i(mshr_ack_word_i),
      .mshr_ack_need_rsp_i(mshr_ack_need_rsp_i), .mshr_ack_is_prefetch_i(mshr_ack_is_prefetch_i),
      .refill_req_o(refill_req_o), .refill_gnt_i(refill_gnt_i),
      .refill_nline_o(refill_nline_o), .refill_beat_o(refill_beat_o),
      .refill_data_o(refill_data_o), .refill_last_o(refill_last_o),
      .refill_error_o(refill_error_o),
      .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
      .core_rsp_tid_o(core_rsp_tid_o), .core_rsp_sid_o(core_rsp_sid_o),
      .core_rsp_data_o(core_rsp_data_o), .core_rsp_error_o(core_rsp_error_o),
      .busy_o(busy_o)
   );

   typedef struct {
      logic vld; logic [6:0] id; logic [1:0] db; logic lst; logic er;
      logic agnt; logic rgnt; logic crdy;
      logic e_ack; logic e_rdy; logic e_req; logic [1:0] e_beat; logic e_last;
      logic e_err; logic e_cval; logic e_busy; logic [63:0] e_cdata; logic e_cerr;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;
   string seg;
   logic [4:0] p_set;
   logic [1:0] p_way;

   // Word w of every line reads as 16'hD000 + w, so beat b carries words 2b, 2b+1.
   function automatic logic [127:0] bd(input logic [1:0] b);
      logic [15:0] lo;
      lo = 16'hD000 + 16'(b) * 16'd2;
      bd = {48'h0, lo + 16'd1, 48'h0, lo};
   endfunction

   function automatic vec_t mk(input logic vld, input logic [6:0] id, input logic [1:0] db,
                               input logic lst, input logic er, input logic agnt,
                               input logic rgnt, input logic crdy, input logic e_ack,
                               input logic e_rdy, input logic e_req, input logic [1:0] e_beat,
                               input logic e_last, input logic e_err, input logic e_cval,
                               input logic e_busy, input logic [63:0] e_cdata, input logic e_cerr);
      vec_t v;
      v.vld = vld; v.id = id; v.db = db; v.lst = lst; v.er = er; v.agnt = agnt;
      v.rgnt = rgnt; v.crdy = crdy; v.e_ack = e_ack; v.e_rdy = e_rdy; v.e_req = e_req;
      v.e_beat = e_beat; v.e_last = e_last; v.e_err = e_err; v.e_cval = e_cval;
      v.e_busy = e_busy; v.e_cdata = e_cdata; v.e_cerr = e_cerr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run_rows();
      for (int i = 0; i < vq.size(); i++) begin
         mem_rsp_valid_i  = vq[i].vld;
         mem_rsp_id_i     = vq[i].id;
         mem_rsp_data_i   = bd(vq[i].db);
         mem_rsp_last_i   = vq[i].lst;
         mem_rsp_error_i  = vq[i].er;
         mshr_ack_gnt_i   = vq[i].agnt;
         refill_gnt_i     = vq[i].rgnt;
         core_rsp_ready_i = vq[i].crdy;
         @(negedge clk_i);
         chk($sformatf("%s[%0d].ack", seg, i), 128'(mshr_ack_o), 128'(vq[i].e_ack));
         chk($sformatf("%s[%0d].ack_cs", seg, i), 128'(mshr_ack_cs_o), 128'(vq[i].e_ack));
         if (vq[i].e_ack) begin
            chk($sformatf("%s[%0d].set", seg, i), 128'(mshr_ack_set_o), 128'(p_set));
            chk($sformatf("%s[%0d].way", seg, i), 128'(mshr_ack_way_o), 128'(p_way));
         end
         chk($sformatf("%s[%0d].mem_ready", seg, i), 128'(mem_rsp_ready_o), 128'(vq[i].e_rdy));
         chk($sformatf("%s[%0d].refill_req", seg, i), 128'(refill_req_o), 128'(vq[i].e_req));
         chk($sformatf("%s[%0d].busy", seg, i), 128'(busy_o), 128'(vq[i].e_busy));
         chk($sformatf("%s[%0d].core_valid", seg, i), 128'(core_rsp_valid_o), 128'(vq[i].e_cval));
         if (vq[i].e_req) begin
            chk($sformatf("%s[%0d].beat", seg, i), 128'(refill_beat_o), 128'(vq[i].e_beat));
            chk($sformatf("%s[%0d].last", seg, i), 128'(refill_last_o), 128'(vq[i].e_last));
            chk($sformatf("%s[%0d].refill_err", seg, i), 128'(refill_error_o), 128'(vq[i].e_err));
            chk($sformatf("%s[%0d].refill_data", seg, i), refill_data_o, bd(vq[i].db));
            chk($sformatf("%s[%0d].nline", seg, i), 128'(refill_nline_o), 128'(mshr_ack_nline_i));
         end
         if (vq[i].e_cval) begin
            chk($sformatf("%s[%0d].core_tid", seg, i), 128'(core_rsp_tid_o), 128'(mshr_ack_req_id_i));
            chk($sformatf("%s[%0d].core_sid", seg, i), 128'(core_rsp_sid_o), 128'(mshr_ack_src_id_i));
            chk($sformatf("%s[%0d].core_data", seg, i), 128'(core_rsp_data_o), 128'(vq[i].e_cdata));
            chk($sformatf("%s[%0d].core_err", seg, i), 128'(core_rsp_error_o), 128'(vq[i].e_cerr));
         end
         @(posedge clk_i);
         #1;
      end
      vq.delete();
   endtask

   initial begin
      rst_ni = 1'b0;
      mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 7'h47; mem_rsp_data_i = '0;
      mem_rsp_error_i = 1'b0; mem_rsp_last_i = 1'b0; mshr_ack_gnt_i = 1'b1;
      refill_gnt_i = 1'b1; core_rsp_ready_i = 1'b0;
      mshr_ack_req_id_i = 6'h2A; mshr_ack_src_id_i = 3'h5;
      mshr_ack_nline_i = 34'h2_1234_5678; mshr_ack_word_i = 3'd5;
      mshr_ack_need_rsp_i = 1'b1; mshr_ack_is_prefetch_i = 1'b0;
      p_set = 5'd7; p_way = 2'd2;

      // Reset state with every request input active.
      #12;
      chk("reset.ack", 128'(mshr_ack_o), 128'(0));
      chk("reset.mem_ready", 128'(mem_rsp_ready_o), 128'(0));
      chk("reset.refill_req", 128'(refill_req_o), 128'(0));
      chk("reset.core_valid", 128'(core_rsp_valid_o), 128'(0));
      chk("reset.busy", 128'(busy_o), 128'(0));
      @(negedge clk_i);
      rst_ni = 1'b1; mem_rsp_valid_i = 1'b0;
      @(posedge clk_i); #1;

      // Back-to-back refill: ack cycle 0, beats cycles 2..5, response cycle 6.
      seg = "b2b";
      vq.push_back(mk(1,7'h47,0,0,0,1,1,0, 1,0,0,0,0,0,0,0,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,1,0, 0,0,0,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,1,0, 0,1,1,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,1,0,0,0,1,0, 0,1,1,1,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,2,0,0,0,1,0, 0,1,1,2,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,3,1,0,0,1,0, 0,1,1,3,1,0,0,1,64'h0,0));
      vq.push_back(mk(0,7'h47,0,0,0,0,1,0, 0,0,0,0,0,0,1,1,64'hD005,0));
      vq.push_back(mk(0,7'h47,0,0,0,0,0,1, 0,0,0,0,0,0,1,1,64'hD005,0));
      vq.push_back(mk(0,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,64'h0,0));
      run_rows();

      // No MSHR grant for 3 cycles, toggling cache grant, error on beat 1.
      seg = "stall_err";
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(1,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,1,0, 0,1,1,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,1,0,1,0,0,0, 0,0,1,1,0,1,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,1,0,1,0,1,0, 0,1,1,1,0,1,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,2,0,0,0,0,0, 0,0,1,2,0,1,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,2,0,0,0,1,0, 0,1,1,2,0,1,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,3,1,0,0,0,0, 0,0,1,3,1,1,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,3,1,0,0,1,0, 0,1,1,3,1,1,0,1,64'h0,0));
      vq.push_back(mk(0,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,64'hD005,1));
      vq.push_back(mk(0,7'h47,0,0,0,0,0,1, 0,0,0,0,0,0,1,1,64'hD005,1));
      vq.push_back(mk(0,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,64'h0,0));
      run_rows();

      // Prefetch without response: line written, then straight back to idle.
      seg = "prefetch";
      mshr_ack_need_rsp_i = 1'b0; mshr_ack_is_prefetch_i = 1'b1;
      vq.push_back(mk(1,7'h47,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,1,0, 0,1,1,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,1,0,0,0,1,0, 0,1,1,1,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,2,0,0,0,1,0, 0,1,1,2,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,3,1,0,0,1,0, 0,1,1,3,1,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h47,0,0,0,0,1,1, 0,0,0,0,0,0,0,0,64'h0,0));
      run_rows();

      // Core back-pressure for 5 cycles while memory offers another beat.
      seg = "core_bp";
      mshr_ack_need_rsp_i = 1'b1; mshr_ack_is_prefetch_i = 1'b0;
      mshr_ack_word_i = 3'd2; mshr_ack_req_id_i = 6'h13; mshr_ack_src_id_i = 3'h2;
      mshr_ack_nline_i = 34'h1_0BAD_CAFE;
      p_set = 5'd3; p_way = 2'd1;
      vq.push_back(mk(1,7'h23,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,64'h0,0));
      vq.push_back(mk(1,7'h23,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h23,0,0,0,0,1,0, 0,1,1,0,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h23,1,0,0,0,1,0, 0,1,1,1,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h23,2,0,0,0,1,0, 0,1,1,2,0,0,0,1,64'h0,0));
      vq.push_back(mk(1,7'h23,3,1,0,0,1,0, 0,1,1,3,1,0,0,1,64'h0,0));
      for (int k = 0; k < 5; k++)
         vq.push_back(mk(1,7'h23,0,0,0,1,1,0, 0,0,0,0,0,0,1,1,64'hD002,0));
      vq.push_back(mk(0,7'h23,0,0,0,0,0,1, 0,0,0,0,0,0,1,1,64'hD002,0));
      vq.push_back(mk(0,7'h23,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,64'h0,0));
      run_rows();

      // Reset in the middle of DATA: everything drops at once.
      mem_rsp_valid_i = 1'b1; mem_rsp_id_i = 7'h47; mem_rsp_data_i = bd(2'd0);
      mem_rsp_last_i = 1'b0; mem_rsp_error_i = 1'b1; mshr_ack_gnt_i = 1'b1;
      refill_gnt_i = 1'b0; core_rsp_ready_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      refill_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("rstmid.pre_refill_req", 128'(refill_req_o), 128'(1));
      @(posedge clk_i); #1;
      mem_rsp_data_i = bd(2'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rstmid.ack", 128'(mshr_ack_o), 128'(0));
      chk("rstmid.mem_ready", 128'(mem_rsp_ready_o), 128'(0));
      chk("rstmid.refill_req", 128'(refill_req_o), 128'(0));
      chk("rstmid.refill_err", 128'(refill_error_o), 128'(0));
      chk("rstmid.core_valid", 128'(core_rsp_valid_o), 128'(0));
      chk("rstmid.busy", 128'(busy_o), 128'(0));
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_error_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rstmid.after_busy", 128'(busy_o), 128'(0));
      chk("rstmid.after_refill_req", 128'(refill_req_o), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
